// File: rtl/vae_fx_pkg.sv
// Shared fixed-point types and helpers for the NIDS-VAE layer engines.
// Activation encodings, FSM states and saturating post-process functions.
package vae_fx_pkg;

    localparam int DW_DEF   = 16;
    localparam int FRAC_DEF = 10;
    localparam int ONE      = 1 << FRAC_DEF;

    typedef enum logic [1:0] {
        ACT_LIN  = 2'd0,
        ACT_RELU = 2'd1,
        ACT_HSIG = 2'd2,
        ACT_LIN3 = 2'd3
    } act_e;

    typedef enum logic [2:0] {
        S_IDLE,
        S_BIAS,
        S_MAC,
        S_DRAIN,
        S_WRITE,
        S_DONE
    } state_e;

    function automatic logic signed [63:0] saturate(
        input logic signed [63:0] v,
        input int                 dw
    );
        logic signed [63:0] hi;
        logic signed [63:0] lo;
        hi = (64'sd1 <<< (dw - 1)) - 64'sd1;
        lo = -(64'sd1 <<< (dw - 1));
        if (v > hi) return hi;
        if (v < lo) return lo;
        return v;
    endfunction

    // (v/4 + 0.5) clamped to [0, 1.0]
    function automatic logic signed [63:0] hard_sigmoid(
        input logic signed [63:0] v,
        input int                 frac
    );
        logic signed [63:0] one;
        logic signed [63:0] t;
        one = 64'sd1 <<< frac;
        t   = (v >>> 2) + (one >>> 1);
        if (t < 0) return 64'sd0;
        if (t > one) return one;
        return t;
    endfunction

endpackage

// File: rtl/fc_layer_bram_lane.sv
// One output neuron: bias load, multiply-accumulate and
// shift/activation/saturation post-process.
module fc_mac_lane
    import vae_fx_pkg::*;
#(
    parameter int DW   = DW_DEF,
    parameter int FRAC = FRAC_DEF,
    parameter int AW   = 2 * DW + 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 load_i,
    input  logic                 add_i,
    input  act_e                 act_i,
    input  logic signed [DW-1:0] w_i,
    input  logic signed [DW-1:0] x_i,
    output logic        [DW-1:0] y_o,
    output logic                 sat_o
);

    logic signed [AW-1:0]   acc_q;
    logic signed [AW-1:0]   acc_d;
    logic signed [2*DW-1:0] prod;
    logic signed [63:0]     sh_v;
    logic signed [63:0]     act_v;
    logic signed [63:0]     sat_v;

    assign prod = w_i * x_i;

    always_comb begin
        acc_d = acc_q;
        if (load_i) begin
            acc_d = AW'(w_i) <<< FRAC;
        end else if (add_i) begin
            acc_d = acc_q + AW'(prod);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acc_q <= '0;
        end else begin
            acc_q <= acc_d;
        end
    end

    always_comb begin
        sh_v = 64'(acc_q >>> FRAC);
        unique case (act_i)
            ACT_RELU: act_v = (sh_v < 0) ? 64'sd0 : sh_v;
            ACT_HSIG: act_v = hard_sigmoid(sh_v, FRAC);
            default:  act_v = sh_v;
        endcase
        sat_v = saturate(act_v, DW);
        y_o   = sat_v[DW-1:0];
        sat_o = (sat_v != act_v);
    end

endmodule

// File: rtl/fc_layer_bram.sv
// Fully-connected layer engine with internal weight/input/output BRAMs.
// Sequencer: bias read, N_IN MAC reads, drain, per-lane write-back.
module fc_layer_bram
    import vae_fx_pkg::*;
#(
    parameter int N_IN  = 9,
    parameter int N_OUT = 2,
    parameter int DW    = DW_DEF,
    parameter int FRAC  = FRAC_DEF
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       en,
    input  logic                       clr,
    input  logic                       start,
    input  logic [1:0]                 act_mode,
    output logic                       ready,
    output logic                       busy,
    output logic                       done,
    output logic                       ovf,
    input  logic                       w_we,
    input  logic [$clog2(N_IN+1)-1:0]  w_addr,
    input  logic [N_OUT*DW-1:0]        w_din,
    input  logic                       x_we,
    input  logic [$clog2(N_IN)-1:0]    x_addr,
    input  logic [DW-1:0]              x_din,
    input  logic                       y_en,
    input  logic [$clog2(N_OUT)-1:0]   y_addr,
    output logic [DW-1:0]              y_dout
);

    localparam int AW   = 2 * DW + $clog2(N_IN + 1);
    localparam int NMAX = (N_IN > N_OUT) ? N_IN : N_OUT;
    localparam int CW   = $clog2(NMAX + 1);
    localparam int WAW  = $clog2(N_IN + 1);
    localparam int XAW  = $clog2(N_IN);
    localparam int YAW  = $clog2(N_OUT);

    state_e          state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    act_e            act_q, act_d;
    logic            ovf_q, ovf_d;
    logic            done_q, done_d;
    logic            y_we;

    logic [N_OUT*DW-1:0] wmem [0:N_IN];
    logic [DW-1:0]       xmem [0:N_IN-1];
    logic [DW-1:0]       ymem [0:N_OUT-1];
    logic [N_OUT*DW-1:0] wrd_q;
    logic [DW-1:0]       xrd_q;
    logic [DW-1:0]       y_dout_q;

    logic [WAW-1:0]      w_ra;
    logic [XAW-1:0]      x_ra;
    logic [YAW-1:0]      wr_idx;
    logic                lane_load;
    logic                lane_add;
    logic [DW-1:0]       lane_y [N_OUT];
    logic [N_OUT-1:0]    lane_sat;

    assign ready  = (state_q == S_IDLE);
    assign busy   = ~ready;
    assign done   = done_q;
    assign ovf    = ovf_q;
    assign y_dout = y_dout_q;

    assign w_ra   = (state_q == S_BIAS) ? WAW'(N_IN) : cnt_q[WAW-1:0];
    assign x_ra   = cnt_q[XAW-1:0];
    assign wr_idx = cnt_q[YAW-1:0];

    // Read data lags the issued address by one enabled cycle
    assign lane_load = en && (state_q == S_MAC) && (cnt_q == '0);
    assign lane_add  = en && (((state_q == S_MAC) && (cnt_q != '0))
                              || (state_q == S_DRAIN));

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        act_d   = act_q;
        ovf_d   = ovf_q;
        done_d  = 1'b0;
        y_we    = 1'b0;
        if (en) begin
            if (clr) begin
                state_d = S_IDLE;
                cnt_d   = '0;
            end else begin
                unique case (state_q)
                    S_IDLE: begin
                        if (start) begin
                            state_d = S_BIAS;
                            act_d   = act_e'(act_mode);
                            ovf_d   = 1'b0;
                        end
                    end
                    S_BIAS: begin
                        state_d = S_MAC;
                        cnt_d   = '0;
                    end
                    S_MAC: begin
                        if (cnt_q == CW'(N_IN - 1)) begin
                            state_d = S_DRAIN;
                            cnt_d   = '0;
                        end else begin
                            cnt_d = cnt_q + CW'(1);
                        end
                    end
                    S_DRAIN: begin
                        state_d = S_WRITE;
                        cnt_d   = '0;
                    end
                    S_WRITE: begin
                        y_we = 1'b1;
                        if (lane_sat[wr_idx]) ovf_d = 1'b1;
                        if (cnt_q == CW'(N_OUT - 1)) begin
                            state_d = S_DONE;
                            cnt_d   = '0;
                        end else begin
                            cnt_d = cnt_q + CW'(1);
                        end
                    end
                    S_DONE: begin
                        state_d = S_IDLE;
                        done_d  = 1'b1;
                    end
                    default: state_d = S_IDLE;
                endcase
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            act_q   <= ACT_LIN;
            ovf_q   <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            act_q   <= act_d;
            ovf_q   <= ovf_d;
            done_q  <= done_d;
        end
    end

    // Host writes are only accepted while idle
    always_ff @(posedge clk) begin
        if (w_we && ready) wmem[w_addr] <= w_din;
        if (x_we && ready) xmem[x_addr] <= x_din;
        if (en) begin
            wrd_q <= wmem[w_ra];
            xrd_q <= xmem[x_ra];
        end
        if (y_we) ymem[wr_idx] <= lane_y[wr_idx];
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            y_dout_q <= '0;
        end else if (y_en) begin
            y_dout_q <= ymem[y_addr];
        end
    end

    for (genvar k = 0; k < N_OUT; k++) begin : g_lane
        fc_mac_lane #(
            .DW   (DW),
            .FRAC (FRAC),
            .AW   (AW)
        ) u_lane (
            .clk    (clk),
            .rst    (rst),
            .load_i (lane_load),
            .add_i  (lane_add),
            .act_i  (act_q),
            .w_i    (wrd_q[k*DW +: DW]),
            .x_i    (xrd_q),
            .y_o    (lane_y[k]),
            .sat_o  (lane_sat[k])
        );
    end

endmodule

// File: tb/tb_fc_layer_bram.sv
// Directed scoreboard bench for fc_layer_bram at default parameters.
// Expected outputs are queued at run start and popped on y reads.
module tb_fc_layer_bram;

    localparam int N_IN  = 9;
    localparam int N_OUT = 2;

    logic        clk = 1'b0;
    logic        rst;
    logic        en;
    logic        clr;
    logic        start;
    logic [1:0]  act_mode;
    logic        ready;
    logic        busy;
    logic        done;
    logic        ovf;
    logic        w_we;
    logic [3:0]  w_addr;
    logic [31:0] w_din;
    logic        x_we;
    logic [3:0]  x_addr;
    logic [15:0] x_din;
    logic        y_en;
    logic [0:0]  y_addr;
    logic [15:0] y_dout;

    int          checks   = 0;
    int          failures = 0;
    logic [15:0] exp_q[$];

    always #5 clk = ~clk;

    fc_layer_bram dut (
        .clk      (clk),
        .rst      (rst),
        .en       (en),
        .clr      (clr),
        .start    (start),
        .act_mode (act_mode),
        .ready    (ready),
        .busy     (busy),
        .done     (done),
        .ovf      (ovf),
        .w_we     (w_we),
        .w_addr   (w_addr),
        .w_din    (w_din),
        .x_we     (x_we),
        .x_addr   (x_addr),
        .x_din    (x_din),
        .y_en     (y_en),
        .y_addr   (y_addr),
        .y_dout   (y_dout)
    );

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, expv);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic load_w(input logic [15:0] l0, input logic [15:0] l1,
                          input logic [15:0] b0, input logic [15:0] b1);
        for (int j = 0; j < N_IN; j++) begin
            w_we = 1'b1; w_addr = 4'(j); w_din = {l1, l0};
            tick();
        end
        w_addr = 4'(N_IN); w_din = {b1, b0};
        tick();
        w_we = 1'b0;
    endtask

    task automatic load_x(input logic [15:0] v);
        for (int j = 0; j < N_IN; j++) begin
            x_we = 1'b1; x_addr = 4'(j); x_din = v;
            tick();
        end
        x_we = 1'b0;
    endtask

    task automatic read_y(input string tag);
        for (int k = 0; k < N_OUT; k++) begin
            y_en = 1'b1; y_addr = 1'(k);
            tick();
            y_en = 1'b0;
            chk($sformatf("%s_y%0d", tag, k), 32'(y_dout), 32'(exp_q.pop_front()));
        end
    endtask

    task automatic run(input logic [1:0] act, input logic [15:0] e0,
                       input logic [15:0] e1, input int exp_lat,
                       input int stall_at, input int dup_at,
                       input int xwe_at, input string tag);
        int lat;
        logic got;
        exp_q.push_back(e0);
        exp_q.push_back(e1);
        act_mode = act;
        start = 1'b1;
        tick();
        start = 1'b0;
        lat = 0;
        got = 1'b0;
        while (!got && lat < 60) begin
            start  = (lat == dup_at);
            x_we   = (lat == xwe_at);
            x_addr = 4'd0;
            x_din  = 16'h7C00;
            en     = !(stall_at >= 0 && lat >= stall_at && lat < stall_at + 3);
            tick();
            lat++;
            if (done) got = 1'b1;
        end
        start = 1'b0; x_we = 1'b0; en = 1'b1;
        chk({tag, "_done"}, 32'(got), 32'd1);
        chk({tag, "_lat"}, 32'(lat), 32'(exp_lat));
        read_y(tag);
    endtask

    initial begin
        int   seen;
        rst = 1'b1; en = 1'b1; clr = 1'b0; start = 1'b0; act_mode = 2'd0;
        w_we = 1'b0; w_addr = '0; w_din = '0;
        x_we = 1'b0; x_addr = '0; x_din = '0;
        y_en = 1'b0; y_addr = '0;
        tick(); tick();
        chk("rst_ready", 32'(ready), 32'd1);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_ovf", 32'(ovf), 32'd0);
        chk("rst_ydout", 32'(y_dout), 32'd0);
        rst = 1'b0;
        tick();

        load_x(16'h0400);
        load_w(16'h0200, 16'h0200, 16'h0100, 16'h0100);
        run(2'd0, 16'h1300, 16'h1300, 14, -1, -1, -1, "base");
        chk("base_ovf", 32'(ovf), 32'd0);

        load_w(16'hFE00, 16'hFE00, 16'h0100, 16'h0100);
        run(2'd1, 16'h0000, 16'h0000, 14, -1, -1, -1, "relu");
        run(2'd0, 16'hEF00, 16'hEF00, 14, -1, -1, -1, "neg");

        load_x(16'h7C00);
        load_w(16'h7C00, 16'h8400, 16'h0100, 16'h0100);
        run(2'd0, 16'h7FFF, 16'h8000, 14, -1, -1, -1, "sat");
        chk("sat_ovf", 32'(ovf), 32'd1);

        load_x(16'h0400);
        load_w(16'h0200, 16'h0200, 16'h0100, 16'h0100);
        run(2'd0, 16'h1300, 16'h1300, 14, -1, -1, -1, "ovfclr");
        chk("ovfclr_ovf", 32'(ovf), 32'd0);

        load_w(16'h0000, 16'h0200, 16'h0000, 16'h0100);
        run(2'd2, 16'h0200, 16'h0400, 14, -1, -1, -1, "hsig");
        chk("hsig_ovf", 32'(ovf), 32'd0);

        load_w(16'h0200, 16'h0200, 16'h0100, 16'h0100);
        run(2'd0, 16'h1300, 16'h1300, 14, -1, 3, 2, "guard");
        run(2'd0, 16'h1300, 16'h1300, 17, 5, -1, -1, "stall");

        act_mode = 2'd0;
        start = 1'b1;
        tick();
        start = 1'b0;
        tick(); tick();
        clr = 1'b1;
        tick();
        clr = 1'b0;
        chk("clr_ready", 32'(ready), 32'd1);
        chk("clr_busy", 32'(busy), 32'd0);
        seen = 0;
        repeat (20) begin
            tick();
            if (done) seen = 1;
        end
        chk("clr_nodone", 32'(seen), 32'd0);

        start = 1'b1;
        tick();
        start = 1'b0;
        tick(); tick(); tick();
        rst = 1'b1;
        #1;
        chk("rst_mid_ready", 32'(ready), 32'd1);
        chk("rst_mid_busy", 32'(busy), 32'd0);
        chk("rst_mid_done", 32'(done), 32'd0);
        tick();
        rst = 1'b0;
        tick();
        run(2'd0, 16'h1300, 16'h1300, 14, -1, -1, -1, "retain");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
